// File: rtl/picotiny_pkg.sv
// Shared constants and types for the PicoTiny SoC boot RAM front-end.
package picotiny_pkg;
  localparam int BOOTRAM_AW    = 13;
  localparam int BOOTRAM_LANES = 4;
  localparam int BOOTRAM_WAW   = BOOTRAM_AW - 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } bootram_state_t;
endpackage

// File: rtl/bootram_2kx8_1.sv
// Behavioural stand-in for the 2Kx8 Gowin single-port block RAM, bypass (write-through) read mode.
module bootram_2kx8_1 (
  input  logic        clk,
  input  logic        oce,
  input  logic        ce,
  input  logic        reset,
  input  logic        wre,
  input  logic [10:0] ad,
  input  logic [7:0]  din,
  output logic [7:0]  dout
);
  logic [7:0] r_mem [0:2047];
  logic [7:0] r_dout;

  always_ff @(posedge clk) begin
    if (ce && wre) r_mem[ad] <= din;
  end

  // Output latch holds its value on cycles without ce; writes pass din straight through.
  always_ff @(posedge clk) begin
    if (reset) r_dout <= '0;
    else if (ce && oce) r_dout <= wre ? din : r_mem[ad];
  end

  assign dout = r_dout;
endmodule

// File: rtl/bootram_picomem_ctrl.sv
// PicoMem front-end for the 8 KB boot RAM: word CPU access plus a sequential byte loader port.
module bootram_picomem_ctrl
  import picotiny_pkg::*;
#(
  parameter bit LOAD_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  mem_valid,
  input  logic [BOOTRAM_AW-1:0] mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [3:0]            mem_wstrb,
  output logic                  mem_ready,
  output logic [31:0]           mem_rdata,
  input  logic                  ld_start,
  input  logic                  ld_valid,
  input  logic [7:0]            ld_data,
  output logic                  ld_ready,
  output logic [BOOTRAM_AW-1:0] ld_count,
  output logic                  ld_full
);
  bootram_state_t        r_state;
  logic                  r_ready;
  logic [31:0]           r_rdata;
  logic                  w_cpu_acc;
  logic                  w_ld_acc;
  logic [BOOTRAM_AW-1:0] w_ld_count;
  logic                  w_ld_full;
  logic [BOOTRAM_WAW-1:0] w_ad;
  logic [BOOTRAM_LANES-1:0] w_ce;
  logic [BOOTRAM_LANES-1:0] w_wre;
  logic [7:0]            w_din  [BOOTRAM_LANES];
  logic [7:0]            w_dout [BOOTRAM_LANES];
  logic                  w_unused_addr;

  assign w_unused_addr = ^mem_addr[1:0];
  assign w_cpu_acc     = resetn && (r_state == ST_IDLE) && mem_valid;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        ST_IDLE:   if (mem_valid) r_state <= ST_ACCESS;
        ST_ACCESS: begin
          r_state <= ST_RESP;
          r_ready <= 1'b1;
        end
        ST_RESP:   r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
    // Lane outputs are valid in ACCESS; capture them for the RESP cycle.
    if (r_state == ST_ACCESS)
      r_rdata <= {w_dout[3], w_dout[2], w_dout[1], w_dout[0]};
  end

  assign mem_ready = r_ready;
  assign mem_rdata = r_ready ? r_rdata : 32'h0;

  if (LOAD_EN) begin : g_loader
    logic [BOOTRAM_AW-1:0] r_ld_count;
    logic                  r_ld_full;

    assign ld_ready = resetn && (r_state == ST_IDLE) && !mem_valid && !r_ld_full && !ld_start;
    assign w_ld_acc = ld_valid && ld_ready;

    always_ff @(posedge clk) begin
      if (!resetn || ld_start) begin
        r_ld_count <= '0;
        r_ld_full  <= 1'b0;
      end else if (w_ld_acc) begin
        r_ld_count <= r_ld_count + 13'd1;
        if (&r_ld_count) r_ld_full <= 1'b1;
      end
    end

    assign w_ld_count = r_ld_count;
    assign w_ld_full  = r_ld_full;
  end else begin : g_no_loader
    logic w_unused_ld;
    assign w_unused_ld = ^{ld_valid, ld_start};
    assign ld_ready    = 1'b0;
    assign w_ld_acc    = 1'b0;
    assign w_ld_count  = '0;
    assign w_ld_full   = 1'b0;
  end

  assign ld_count = w_ld_count;
  assign ld_full  = w_ld_full;

  assign w_ad = w_cpu_acc ? mem_addr[BOOTRAM_AW-1:2] : w_ld_count[BOOTRAM_AW-1:2];

  // A loader byte enables only the lane selected by the low count bits.
  for (genvar gi = 0; gi < BOOTRAM_LANES; gi++) begin : g_lane
    assign w_ce[gi]  = w_cpu_acc || (w_ld_acc && (w_ld_count[1:0] == 2'(gi)));
    assign w_wre[gi] = w_cpu_acc ? mem_wstrb[gi] : w_ld_acc;
    assign w_din[gi] = w_cpu_acc ? mem_wdata[8*gi +: 8] : ld_data;

    bootram_2kx8_1 u_ram (
      .clk   (clk),
      .oce   (1'b1),
      .ce    (w_ce[gi]),
      .reset (1'b0),
      .wre   (w_wre[gi]),
      .ad    (w_ad),
      .din   (w_din[gi]),
      .dout  (w_dout[gi])
    );
  end
endmodule

// File: tb/tb_bootram_picomem_ctrl.sv
// Directed bench for bootram_picomem_ctrl, with a second LOAD_EN=0 instance sharing the stimulus.
module tb_bootram_picomem_ctrl;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_valid = 1'b0;
  logic [12:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        ld_start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_data = '0;

  logic        mem_ready, ld_ready, ld_full;
  logic [31:0] mem_rdata;
  logic [12:0] ld_count;
  logic        mem_ready_nl, ld_ready_nl, ld_full_nl;
  logic [31:0] mem_rdata_nl;
  logic [12:0] ld_count_nl;

  int n_chk  = 0;
  int n_fail = 0;

  bootram_picomem_ctrl #(.LOAD_EN(1'b1)) u_dut (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .ld_count(ld_count), .ld_full(ld_full)
  );

  bootram_picomem_ctrl #(.LOAD_EN(1'b0)) u_dut_nl (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready_nl), .mem_rdata(mem_rdata_nl),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready_nl),
    .ld_count(ld_count_nl), .ld_full(ld_full_nl)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One CPU transfer: ready must appear exactly two cycles after the request is sampled.
  task automatic cpu_xfer(input string tag, input logic [12:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, input logic [31:0] mask,
                          input logic [31:0] exp, input bit chk_nl);
    mem_addr  = a;
    mem_wdata = wd;
    mem_wstrb = ws;
    mem_valid = 1'b1;
    tick();
    check({tag, "_rdy_n1"}, 32'(mem_ready), 32'd0);
    tick();
    check({tag, "_rdy_n2"}, 32'(mem_ready), 32'd1);
    check({tag, "_rdy_n2_nl"}, 32'(mem_ready_nl), 32'd1);
    if (ws == 4'b0000) begin
      check({tag, "_rdata"}, mem_rdata & mask, exp);
      if (chk_nl) check({tag, "_rdata_nl"}, mem_rdata_nl & mask, exp);
    end
    mem_valid = 1'b0;
    mem_wstrb = 4'b0000;
    tick();
    check({tag, "_rdy_n3"}, 32'(mem_ready), 32'd0);
    check({tag, "_rdata_n3"}, mem_rdata, 32'd0);
  endtask

  initial begin
    int stalls;
    int nl_rdy;
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls;
    int nl_rdy;
    logic [7:0] bytes4 [4];
    bytes4[0] = 8'h13; bytes4[1] = 8'h00; bytes4[2] = 8'h00; bytes4[3] = 8'h00;

    // Reset values
    repeat (3) tick();
    check("rst_mem_ready", 32'(mem_ready), 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_ld_count", 32'(ld_count), 32'd0);
    check("rst_ld_full", 32'(ld_full), 32'd0);
    resetn = 1'b1;
    #1;
    check("idle_ld_ready", 32'(ld_ready), 32'd1);
    check("idle_ld_ready_nl", 32'(ld_ready_nl), 32'd0);

    // ld_start beats a simultaneous byte, then load a 4-byte word
    ld_start = 1'b1; ld_valid = 1'b1; ld_data = 8'hAA;
    #1;
    check("start_ld_ready", 32'(ld_ready), 32'd0);
    tick();
    ld_start = 1'b0;
    check("start_ld_count", 32'(ld_count), 32'd0);
    for (int i = 0; i < 4; i++) begin
      ld_data = bytes4[i];
      tick();
    end
    ld_valid = 1'b0;
    check("load4_count", 32'(ld_count), 32'd4);
    cpu_xfer("rd0", 13'h0000, 32'h0, 4'b0000, 32'hFFFF_FFFF, 32'h0000_0013, 1'b0);

    // Byte-strobe write: lanes 0 and 2 take EF and AD
    cpu_xfer("wr10a", 13'h0010, 32'h1122_3344, 4'b1111, 32'hFFFF_FFFF, 32'h0, 1'b0);
    cpu_xfer("wr10b", 13'h0010, 32'hDEAD_BEEF, 4'b0101, 32'hFFFF_FFFF, 32'h0, 1'b0);
    cpu_xfer("rd10", 13'h0010, 32'h0, 4'b0000, 32'hFFFF_FFFF, 32'h11AD_33EF, 1'b1);

    // CPU and loader request together: CPU first, byte lands after return to IDLE
    mem_addr = 13'h0010; mem_wstrb = 4'b0000; mem_valid = 1'b1;
    ld_valid = 1'b1; ld_data = 8'h5A;
    #1;
    check("prio_ldrdy_idle", 32'(ld_ready), 32'd0);
    tick();
    check("prio_ldrdy_access", 32'(ld_ready), 32'd0);
    check("prio_count_access", 32'(ld_count), 32'd4);
    tick();
    check("prio_mem_ready", 32'(mem_ready), 32'd1);
    check("prio_ldrdy_resp", 32'(ld_ready), 32'd0);
    check("prio_rdata", mem_rdata, 32'h11AD_33EF);
    mem_valid = 1'b0;
    tick();
    check("prio_ldrdy_back", 32'(ld_ready), 32'd1);
    check("prio_count_back", 32'(ld_count), 32'd4);
    tick();
    ld_valid = 1'b0;
    check("prio_count_land", 32'(ld_count), 32'd5);
    cpu_xfer("rd4", 13'h0004, 32'h0, 4'b0000, 32'h0000_00FF, 32'h0000_005A, 1'b0);

    // Stream the full 8 KB
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b1;
    stalls = 0;
    nl_rdy = 0;
    for (int i = 0; i < 8192; i++) begin
      ld_data = 8'(i) ^ 8'h3C;
      #1;
      if (!ld_ready) stalls++;
      if (ld_ready_nl) nl_rdy++;
      @(posedge clk);
      #1;
    end
    check("stream_stalls", 32'(stalls), 32'd0);
    check("stream_nl_ready", 32'(nl_rdy), 32'd0);
    check("full_flag", 32'(ld_full), 32'd1);
    check("full_count", 32'(ld_count), 32'd0);
    check("full_ld_ready", 32'(ld_ready), 32'd0);
    check("nl_count", 32'(ld_count_nl), 32'd0);
    check("nl_full", 32'(ld_full_nl), 32'd0);
    ld_data = 8'hFF;
    repeat (3) tick();
    ld_valid = 1'b0;
    check("full_count_hold", 32'(ld_count), 32'd0);
    cpu_xfer("rd_first", 13'h0000, 32'h0, 4'b0000, 32'hFFFF_FFFF, 32'h3F3E_3D3C, 1'b0);
    cpu_xfer("rd_last", 13'h1FFC, 32'h0, 4'b0000, 32'hFFFF_FFFF, 32'hC3C2_C1C0, 1'b0);
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    #1;
    check("restart_full", 32'(ld_full), 32'd0);
    check("restart_ld_ready", 32'(ld_ready), 32'd1);

    // Reset in ACCESS drops the request but keeps RAM contents
    cpu_xfer("wr20", 13'h0020, 32'hCAFE_F00D, 4'b1111, 32'hFFFF_FFFF, 32'h0, 1'b0);
    ld_valid = 1'b1; ld_data = 8'h77;
    tick();
    ld_valid = 1'b0;
    check("pre_rst_count", 32'(ld_count), 32'd1);
    mem_addr = 13'h0020; mem_wstrb = 4'b0000; mem_valid = 1'b1;
    tick();
    resetn = 1'b0;
    tick();
    check("midrst_mem_ready", 32'(mem_ready), 32'd0);
    check("midrst_mem_ready_nl", 32'(mem_ready_nl), 32'd0);
    check("midrst_rdata", mem_rdata, 32'd0);
    check("midrst_count", 32'(ld_count), 32'd0);
    mem_valid = 1'b0;
    resetn = 1'b1;
    tick();
    check("postrst_mem_ready", 32'(mem_ready), 32'd0);
    check("postrst_ld_ready", 32'(ld_ready), 32'd1);
    cpu_xfer("rd20", 13'h0020, 32'h0, 4'b0000, 32'hFFFF_FFFF, 32'hCAFE_F00D, 1'b1);
    cpu_xfer("rd0_after", 13'h0000, 32'h0, 4'b0000, 32'hFFFF_FFFF, 32'h3F3E_3D77, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
